// File: rtl/tia_dl_bank.sv
// rtl/tia_dl_bank.sv - maskable bank of sticky set-until-cleared latches
//
// Purpose:
//   WIDTH independent latches that set on a requested, enabled input and stay
//   set until reset or a synchronous clear.
//   Capture happens in two stages on the same clock:
//     - The sample stage registers the enabled request.
//     - The commit stage ORs that sample into the latch state.
//   A request present at edge n is therefore visible on out after edge n+1.
//   EDGE selects the capture mode: level capture, or rising-edge capture of each input.
//   A registered 2-bit read port returns one latch pair per address.
//
// Ports:
//   clk      in   1       clock, all state on posedge
//   r        in   1       asynchronous reset, active-high
//   clr      in   1       synchronous clear of latches and sample stage
//   in       in   WIDTH   per-channel set request
//   en       in   WIDTH   per-channel capture enable (1 = armed)
//   rd_addr  in   ADDR_W  selects latch pair {2a+1, 2a}
//   rd_data  out  2       registered read of the selected pair
//   out      out  WIDTH   latch state
//   any      out  1       OR of all latches, same cycle as out

module tia_dl_bank #(
  parameter int WIDTH  = 15,
  parameter int EDGE   = 0,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              r,
  input  logic              clr,
  input  logic [WIDTH-1:0]  in,
  input  logic [WIDTH-1:0]  en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        rd_data,
  output logic [WIDTH-1:0]  out,
  output logic              any
);

  // Read space is always a whole number of pairs; bits above WIDTH read 0.
  localparam int PAD_W = 2 * (2 ** ADDR_W);

  logic [WIDTH-1:0] samp;
  logic [WIDTH-1:0] req;
  logic [PAD_W-1:0] out_pad;

  generate
    if (EDGE != 0) begin : g_edge
      // in_d clears on reset, so an input already high at reset release
      // is treated as a fresh rising edge.
      logic [WIDTH-1:0] in_d;

      // in_d keeps tracking the input through clr, so a held input does not
      // register as a new edge after a clear.
      always_ff @(posedge clk or posedge r) begin
        if (r) begin
          in_d <= '0;
        end else begin
          in_d <= in;
        end
      end

      assign req = in & ~in_d & en;
    end else begin : g_level
      assign req = in & en;
    end
  endgenerate

  // Clear beats set.
  // clr discards both the request sampled at the clr edge and the one
  // already waiting in samp.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      samp <= '0;
      out  <= '0;
    end else if (clr) begin
      samp <= '0;
      out  <= '0;
    end else begin
      samp <= req;
      out  <= out | samp;
    end
  end

  always_comb begin
    out_pad              = '0;
    out_pad[WIDTH-1:0]   = out;
  end

  // The read port registers the current latch state, so it lags out by one cycle.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      rd_data <= 2'b00;
    end else begin
      rd_data <= out_pad[{rd_addr, 1'b0} +: 2];
    end
  end

  assign any = |out;

endmodule
